// File: rtl/demux_pkg.sv
// Shared types and constants for the serial front-end of the 1:8 demux.
// Defining DEMUX_FRAME_PARITY_EN adds a PARITY state and widens the state encoding.
package demux_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

`ifdef DEMUX_FRAME_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    STOP = 2'd3
  } state_t;
`endif

  // A counter must be at least one bit wide even for a single-bit payload.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/demux_frame_router_if.sv
// Bundle between the serial source and the frame router, plus the demux-side outputs.
// rx_valid qualifies rx_bit; there is no ready, every cycle with rx_valid=1 consumes one bit.
interface demux_frame_router_if;
  import demux_pkg::*;

  logic             rx_valid;
  logic             rx_bit;
  logic [SEL_W-1:0] sel;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             frame_done;
  logic             frame_err;
  state_t           state;

  modport master (
    output rx_valid, rx_bit,
    input  sel, dout, dout_valid, busy, frame_done, frame_err, state
  );

  modport slave (
    input  rx_valid, rx_bit,
    output sel, dout, dout_valid, busy, frame_done, frame_err, state
  );

endinterface

// File: rtl/demux_frame_router_frame_bit_counter.sv
// Loadable up-counter that flags its terminal count and wraps to zero when stepped past it.
module frame_bit_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] tc_val_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o  = (cnt_q == tc_val_i);
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/demux_frame_router.sv
// Decodes start/address/payload/stop frames and drives the 1:8 demux select and data.
// Optional DEMUX_FRAME_PARITY_EN adds an even-parity bit checked before the stop bit.
module demux_frame_router
    import demux_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    demux_frame_router_if.slave bus
);

    localparam int DCW = cnt_w(DATA_BITS);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [1:0]       addr_shift_q, addr_shift_d;
    logic             dout_q, dout_d;
    logic             dv_q, dv_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             frame_ok;

    logic             acc;
    logic             addr_tc, data_tc;
    logic [1:0]       addr_cnt;
    logic [DCW-1:0]   data_cnt;

`ifdef DEMUX_FRAME_PARITY_EN
    logic par_q, par_d;
    logic perr_q, perr_d;
`endif

    assign acc = bus.rx_valid;

    frame_bit_counter #(.W(2)) u_addr_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (state_q == IDLE && acc && bus.rx_bit == START_BIT),
        .load_val_i (2'd0),
        .en_i       (state_q == ADDR && acc),
        .tc_val_i   (2'(SEL_W - 1)),
        .cnt_o      (addr_cnt),
        .tc_o       (addr_tc)
    );

    frame_bit_counter #(.W(DCW)) u_data_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (state_q == ADDR && acc && addr_tc),
        .load_val_i ('0),
        .en_i       (state_q == DATA && acc),
        .tc_val_i   (DCW'(DATA_BITS - 1)),
        .cnt_o      (data_cnt),
        .tc_o       (data_tc)
    );

    // A frame succeeds only on a correct stop bit (and, if enabled, correct parity).
`ifdef DEMUX_FRAME_PARITY_EN
    assign frame_ok = (bus.rx_bit == STOP_BIT) && !perr_q;
`else
    assign frame_ok = (bus.rx_bit == STOP_BIT);
`endif

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        addr_shift_d = addr_shift_q;
        dout_d       = 1'b0;
        dv_d         = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
`ifdef DEMUX_FRAME_PARITY_EN
        par_d        = par_q;
        perr_d       = perr_q;
`endif
        if (acc) begin
            case (state_q)
                IDLE: begin
                    if (bus.rx_bit == START_BIT) begin
                        state_d = ADDR;
`ifdef DEMUX_FRAME_PARITY_EN
                        par_d   = 1'b0;
                        perr_d  = 1'b0;
`endif
                    end
                end
                ADDR: begin
                    addr_shift_d = {addr_shift_q[0], bus.rx_bit};
`ifdef DEMUX_FRAME_PARITY_EN
                    par_d        = par_q ^ bus.rx_bit;
`endif
                    if (addr_tc) begin
                        sel_d   = {addr_shift_q, bus.rx_bit};
                        state_d = DATA;
                    end
                end
                DATA: begin
                    dout_d = bus.rx_bit;
                    dv_d   = 1'b1;
`ifdef DEMUX_FRAME_PARITY_EN
                    par_d  = par_q ^ bus.rx_bit;
                    if (data_tc) state_d = PARITY;
`else
                    if (data_tc) state_d = STOP;
`endif
                end
`ifdef DEMUX_FRAME_PARITY_EN
                PARITY: begin
                    perr_d  = par_q ^ bus.rx_bit;
                    state_d = STOP;
                end
`endif
                STOP: begin
                    done_d  = frame_ok;
                    err_d   = !frame_ok;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            addr_shift_q <= '0;
            dout_q       <= 1'b0;
            dv_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef DEMUX_FRAME_PARITY_EN
            par_q        <= 1'b0;
            perr_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            addr_shift_q <= addr_shift_d;
            dout_q       <= dout_d;
            dv_q         <= dv_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef DEMUX_FRAME_PARITY_EN
            par_q        <= par_d;
            perr_q       <= perr_d;
`endif
        end
    end

    assign bus.sel        = sel_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;
    assign bus.state      = state_q;

    logic unused_ok;
    assign unused_ok = ^{addr_cnt, data_cnt};

endmodule
